// File: rtl/sd_pkg.sv
// sd_pkg -- shared definitions for the sigma-delta CIC decimator.
//   CIC_ORDER  : number of integrator/comb stages.
//   cic_width  : minimum internal word width for a given log2(R); the CIC
//                gain is R**CIC_ORDER, plus a sign bit and one bit of headroom
//                so that +R**3 (exact full scale) is representable.
//   bit_to_pm1 : maps a bitstream bit to a 2-bit signed +1 / -1.
package sd_pkg;

  localparam int CIC_ORDER = 3;

  function automatic int cic_width(input int log2_r);
    return CIC_ORDER * log2_r + 2;
  endfunction

  function automatic logic signed [1:0] bit_to_pm1(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// sd_cic_integrator -- W-bit enabled accumulator, one CIC integrator stage.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high clear
//   enb   : clock enable; accumulator holds while low
//   x     : signed W-bit increment
//   acc   : signed W-bit registered running sum (wraps modulo 2**W)
module sd_cic_integrator #(
  parameter int W = 17
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] acc
);

  // Wrap-around is intentional: the combs recover the exact result modulo 2**W.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (enb) begin
      acc <= acc + x;
    end
  end

endmodule

// File: rtl/sd_decimator.sv
// sd_decimator -- 3rd-order CIC decimator by R = 2**LOG2_R for a 1-bit
// sigma-delta stream. Three pipelined integrators run at the input rate;
// three combs (differential delay 1) run once per R enabled cycles.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset (wins over enb)
//   enb    : clock enable; when low no state advances
//   in     : bitstream, 1 -> +1, 0 -> -1
//   out    : signed W-bit PCM sample, LOG2_R*3 fraction bits (+R**3 = +1.0)
//   valid  : one-clock strobe marking a new value on out
//   ce_out : combinational copy of enb
module sd_decimator
  import sd_pkg::*;
#(
  parameter int LOG2_R = 5,
  parameter int W      = cic_width(LOG2_R)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enb,
  input  logic                in,
  output logic signed [W-1:0] out,
  output logic                valid,
  output logic                ce_out
);

  if (LOG2_R < 1 || LOG2_R > 8) begin : g_bad_ratio
    $error("sd_decimator: LOG2_R must be in 1..8");
  end
  if (W < cic_width(LOG2_R)) begin : g_bad_width
    $error("sd_decimator: W too small for LOG2_R");
  end

  localparam logic [LOG2_R-1:0] LAST = '1;

  logic signed [1:0]   pm;
  logic signed [W-1:0] x;
  logic signed [W-1:0] i1, i2, i3;
  logic signed [W-1:0] d1, d2, d3;
  logic signed [W-1:0] c1, c2, c3;
  logic signed [W-1:0] out_p1;
  logic [LOG2_R-1:0]   cnt;
  logic                last;
  logic                vld_p1;

  assign pm = bit_to_pm1(in);
  assign x  = {{(W-2){pm[1]}}, pm};

  // Input-rate integrators; each stage consumes the previous stage's
  // registered (pre-update) value, giving one cycle of latency per stage.
  sd_cic_integrator #(.W(W)) u_int1 (
    .clk(clk), .reset(reset), .enb(enb), .x(x),  .acc(i1)
  );
  sd_cic_integrator #(.W(W)) u_int2 (
    .clk(clk), .reset(reset), .enb(enb), .x(i1), .acc(i2)
  );
  sd_cic_integrator #(.W(W)) u_int3 (
    .clk(clk), .reset(reset), .enb(enb), .x(i2), .acc(i3)
  );

  assign last = (cnt == LAST);

  always_comb begin
    c1 = i3 - d1;
    c2 = c1 - d2;
    c3 = c2 - d3;
  end

  // Output-rate comb delays and output register, updated on the last
  // enabled cycle of each frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      vld_p1 <= 1'b0;
      d1     <= '0;
      d2     <= '0;
      d3     <= '0;
      out_p1 <= '0;
    end else if (enb) begin
      cnt    <= cnt + 1'b1;
      vld_p1 <= last;
      if (last) begin
        d1     <= i3;
        d2     <= c1;
        d3     <= c2;
        out_p1 <= c3;
      end
    end
  end

  // The strobe flag holds with everything else while enb is low; gating it
  // keeps valid low in stalled cycles and presents it on the next enabled one.
  assign out    = out_p1;
  assign valid  = vld_p1 & enb;
  assign ce_out = enb;

endmodule

// File: doc/sd_decimator.md
SD_DECIMATOR -- requirements
Module: sd_decimator

Interface
REQ-001 Parameter LOG2_R, default 5, log2 of the decimation ratio R = 2**LOG2_R; legal range 1..8.
REQ-002 Parameter W, default 3*LOG2_R+2, is the output and internal word width; W shall not be set below 3*LOG2_R+2.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port enb, input, 1 bit: clock enable; when low, the block advances no state.
REQ-006 Port in, input, 1 bit: the sigma-delta bitstream; 1 maps to +1 and 0 maps to -1.
REQ-007 Port out, output, signed W bits: decimated PCM sample, fixed point with LOG2_R*3 fraction bits; +R**3 is +1.0.
REQ-008 Port valid, output, 1 bit: one-clock strobe that marks a new value on out.
REQ-009 Port ce_out, output, 1 bit: combinational copy of enb.

Function
REQ-010 The block shall implement a 3rd-order CIC decimator by R: three integrators at input rate, then three combs (differential delay 1) at output rate.
REQ-011 The integrators shall be registered and pipelined: each enabled cycle, i1<=i1+x, i2<=i2+i1, i3<=i3+i2, using pre-update values; all arithmetic is W-bit two's complement with silent wrap.
REQ-012 A decimation counter shall count 0..R-1 on enabled cycles and wrap to 0 after R-1.
REQ-013 On an enabled cycle with counter==R-1, the block shall sample i3 (the pre-update value) into the comb chain, c1=i3-d1, c2=c1-d2, c3=c2-d3, and update d1<=i3, d2<=c1, d3<=c2.
REQ-014 In the same cycle, out shall register c3 and valid shall be 1 on the following clock, for exactly one clock.
REQ-015 out shall hold its value between strobes; valid shall be 0 on every other cycle.
REQ-016 With enb low, all registers shall hold, including the counter, integrators, comb delays and out, and valid shall be 0.
REQ-017 Strobes shall be spaced exactly R enabled cycles apart; the first strobe occurs R enabled cycles after reset deasserts.
REQ-018 For constant input, out shall equal +R**3 (all ones) or -R**3 (all zeros) exactly from the 5th strobe onward.
REQ-019 Integrator wrap shall not corrupt the output: results are exact modulo 2**W, and the true result always fits W bits.
REQ-020 If reset and enb are both high in the same cycle, reset shall win.

Reset
REQ-021 When reset is high at a clock edge, the block shall clear the counter, i1..i3, d1..d3 and out to 0, and clear valid to 0.
REQ-022 Reset asserted mid-decimation shall discard the partial frame; counting restarts at 0 on the first enabled cycle after release.

Structure
REQ-023 A shared package sd_pkg shall hold CIC_ORDER=3, the bitstream-to-±1 mapping function, and the width-derivation function for W.
REQ-024 One sub-module, sd_cic_integrator (a parameterised W-bit enabled accumulator with synchronous reset), shall be instantiated three times; the combs, counter and output register stay in the top.

Verification (R=32, W=17)
REQ-025 Reset, then in=1 constant with enb=1: valid every 32 cycles, first strobe 32 cycles after release; out=+32768 from the 5th strobe onward.
REQ-026 in=0 constant: out=-32768 from the 5th strobe onward.
REQ-027 in alternating 1,0: out=0 exactly from the 5th strobe onward.
REQ-028 Input stream from the second-order modulator driven with a constant 0.25 (sfix16_En7 value 32): the mean of out over 64 strobes is within ±1% of +8192.
REQ-029 enb toggled pseudo-randomly at 50% with in=1: strobes every 32 enabled cycles, valid never high while enb is low, and the settled value is still +32768.
REQ-030 Reset pulsed at counter=17 mid-stream: out=0 and valid=0 the next cycle; the next strobe comes 32 enabled cycles after release.
